// File: rtl/bcd_stopwatch_ctrl_pkg.sv
// bcd_stopwatch_ctrl_pkg: shared state encoding and BCD limits for the stopwatch controller
package bcd_stopwatch_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_t;
  localparam logic [3:0] BCD_MAX = 4'd9;
endpackage

// File: rtl/bcd_stopwatch_ctrl_if.sv
// bcd_stopwatch_ctrl_if: button requests in, live/display count and status out
interface bcd_stopwatch_ctrl_if #(parameter int NDIG = 2);
  logic btn_ss;
  logic btn_lap;
  logic btn_rst;
  logic [4*NDIG-1:0] count;
  logic [4*NDIG-1:0] disp;
  logic running;
  logic lap_active;
  logic ovf;
  modport master (
    output btn_ss, btn_lap, btn_rst,
    input  count, disp, running, lap_active, ovf
  );
  modport slave (
    input  btn_ss, btn_lap, btn_rst,
    output count, disp, running, lap_active, ovf
  );
endinterface

// File: rtl/bcd_stopwatch_ctrl_digit.sv
// bcd_digit: one synchronous mod-10 counter stage with terminal-count output
module bcd_digit
  import bcd_stopwatch_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       clear,
  input  logic       zero,
  input  logic       en,
  output logic [3:0] q,
  output logic       tc
);
  // An out-of-range value counts as terminal, so the next tick forces 0 and carries.
  assign tc = q >= BCD_MAX;
  always_ff @(posedge clk or negedge clear)
    if (!clear) q <= '0;
    else q <= zero ? '0 : !en ? q : tc ? '0 : q + 4'd1;
endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// bcd_stopwatch_ctrl: run/stop/lap FSM, tick prescaler, BCD digit chain and lap display freeze
module bcd_stopwatch_ctrl
  import bcd_stopwatch_ctrl_pkg::*;
#(
  parameter int NDIG = 2,
  parameter int DIV  = 4
) (
  input  logic clk,
  input  logic clear,
  bcd_stopwatch_ctrl_if.slave sw
);
  localparam int PW = $clog2(DIV);
  state_t state, nstate;
  logic [PW-1:0] presc;
  logic [NDIG:0] carry;
  logic [NDIG-1:0] tc;
  logic [4*NDIG-1:0] count, lap_q;
  logic lap_valid, ovf, tick, active, zero;
  assign active = (state == RUN) || (state == LAP);
  assign tick   = active && (presc == PW'(DIV - 1));
  assign zero   = (state == PAUSE) && !sw.btn_ss && sw.btn_rst;
  always_ff @(posedge clk or negedge clear)
    if (!clear) state <= IDLE;
    else state <= nstate;
  always_comb begin
    nstate = state;
    case (state)
      IDLE:  nstate = sw.btn_ss ? RUN : IDLE;
      RUN:   nstate = sw.btn_ss ? PAUSE : sw.btn_lap ? LAP : RUN;
      LAP:   nstate = sw.btn_ss ? PAUSE : sw.btn_lap ? RUN : LAP;
      PAUSE: nstate = sw.btn_ss ? RUN : sw.btn_rst ? IDLE : PAUSE;
    endcase
  end
  always_comb begin
    carry[0] = tick;
    for (int k = 0; k < NDIG; k++) carry[k+1] = carry[k] & tc[k];
  end
  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    bcd_digit u_dig (
      .clk   (clk),
      .clear (clear),
      .zero  (zero),
      .en    (carry[i]),
      .q     (count[4*i +: 4]),
      .tc    (tc[i])
    );
  end
  // During the first LAP cycle the live count is the frozen value; it is copied into lap_q
  // on the following edge, so no separate next-count logic is needed.
  always_ff @(posedge clk or negedge clear)
    if (!clear) begin
      presc     <= '0;
      ovf       <= 1'b0;
      lap_q     <= '0;
      lap_valid <= 1'b0;
    end else begin
      presc     <= (state == IDLE || zero || tick) ? '0 : active ? presc + 1'b1 : presc;
      ovf       <= zero ? 1'b0 : ovf | carry[NDIG];
      lap_valid <= (state == LAP) && (nstate == LAP);
      if (state == LAP && !lap_valid) lap_q <= count;
    end
  always_comb begin
    sw.count      = count;
    sw.disp       = (state == LAP && lap_valid) ? lap_q : count;
    sw.running    = active;
    sw.lap_active = state == LAP;
    sw.ovf        = ovf;
  end
endmodule
